mlp_result_writer: RTL and testbench

Parametrised successor to the current MLP output-buffer path: accepts the classifier's per-image score stream and writes it into the output buffer with byte addressing.
- Generalises image count, class count, data/address width and address stride.
- Adds an argmax mode that writes one predicted-class index per image instead of raw scores.
- Adds stream back-pressure, error flagging and done IRQ/LED generation.
- Sits between the MLP core's result stream and the y_buf BRAM port in the top level.

---
 rtl/mlp_pkg.sv | 35 +++
 rtl/mlp_fp_argmax.sv | 38 +++
 rtl/mlp_result_writer.sv | 188 ++++++++++++++++++
 tb/tb_mlp_result_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP result writer: run modes, FSM state
// encoding and the order-preserving key used to compare scores.
package mlp_pkg;

   localparam int MODE_RAW    = 0;
   localparam int MODE_ARGMAX = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } fsm_state_e;

   // Maps an IEEE-754 single onto an unsigned key with the same ordering:
   // positives get the MSB set, negatives are fully inverted so that a
   // larger magnitude becomes a smaller key.
   function automatic logic [31:0] fp32_order_key(input logic [31:0] v);
      logic [31:0] k;
      if (v[31]) k = ~v;
      else       k = {1'b1, v[30:0]};
      return k;
   endfunction

   // Width-generic ordering key: FP32 ordering for 32-bit scores, signed
   // two's-complement ordering (MSB flip) for any other width. Bits above
   // w stay zero as long as v is zero-extended by the caller.
   function automatic logic [63:0] score_key(input logic [63:0] v, input int w);
      logic [63:0] k;
      if (w == 32) k = {32'd0, fp32_order_key(v[31:0])};
      else         k = v ^ (64'd1 << (w - 1));
      return k;
   endfunction

endpackage

// File: rtl/mlp_fp_argmax.sv
// Running maximum of one image's scores. Holds the best key seen so far
// and the class index it came from; a sample flagged 'clear' starts a new
// image and is taken unconditionally. Ties keep the earlier (lower) index.
module mlp_fp_argmax
   import mlp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   input  logic [IDX_W-1:0]  idx,
   output logic [IDX_W-1:0]  max_idx,
   output logic [DATA_W-1:0] max_key
);

   logic [DATA_W-1:0] key;
   logic [DATA_W-1:0] best_key_p1;
   logic [IDX_W-1:0]  best_idx_p1;
   logic              take;

   assign key  = DATA_W'(score_key(64'(data), DATA_W));
   assign take = valid && (clear || (key > best_key_p1));

   // Capture a new best only on a strictly greater key or on image start.
   always_ff @(posedge clk) begin
      if (take) begin
         best_key_p1 <= key;
         best_idx_p1 <= idx;
      end
   end

   assign max_idx = best_idx_p1;
   assign max_key = best_key_p1;

endmodule

// File: rtl/mlp_result_writer.sv
// Accepts the classifier score stream and writes it to the y_buf BRAM port,
// either as raw scores (one word per score) or as one argmax class index
// per image. Also generates busy, sticky error and done IRQ/LED signals.
module mlp_result_writer
   import mlp_pkg::*;
#(
   parameter int IMG_NUM    = 10,
   parameter int CLASS_NUM  = 10,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int BYTE_SHIFT = 2,
   parameter int MODE       = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              y_buf_en,
   output logic              y_buf_wr_en,
   output logic [ADDR_W-1:0] y_buf_addr,
   output logic [DATA_W-1:0] y_buf_data,
   output logic              busy_o,
   output logic              err_o,
   output logic              done_intr_o,
   output logic              done_led_o
);

   localparam int IMG_W  = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1;
   localparam int CLS_W  = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
   localparam int WORD_W = (IMG_NUM * CLASS_NUM > 1) ? $clog2(IMG_NUM * CLASS_NUM) : 1;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_FLUSH = FLUSH;
   localparam logic [1:0] ST_DONE  = DONE;

   logic [1:0]        state;
   logic [IMG_W-1:0]  img_cnt;
   logic [CLS_W-1:0]  class_cnt;
   logic [WORD_W-1:0] word_cnt;
   logic              err_q;
   logic              led_q;

   logic              accept;
   logic              class_last;
   logic              img_last;
   logic [CLS_W-1:0]  fin_idx;

   logic              wr_en_p1;
   logic              last_wr_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [DATA_W-1:0] data_p1;
   logic              done_p2;

   assign s_ready_o  = (state == ST_RUN);
   assign busy_o     = (state == ST_RUN) || (state == ST_FLUSH);
   assign accept     = s_valid_i && s_ready_o;
   assign class_last = (class_cnt == CLS_W'(CLASS_NUM - 1));
   assign img_last   = (img_cnt == IMG_W'(IMG_NUM - 1));

   // Argmax tracking exists only in argmax mode. The tracker holds the best
   // of the scores already accepted; the score being accepted now is merged
   // here so the image result is ready at the same edge as its last score.
   if (MODE == MODE_ARGMAX) begin : g_argmax
      logic [DATA_W-1:0] in_key;
      logic [DATA_W-1:0] best_key;
      logic [CLS_W-1:0]  best_idx;
      logic              first;

      assign first  = (class_cnt == '0);
      assign in_key = DATA_W'(score_key(64'(s_data_i), DATA_W));

      mlp_fp_argmax #(
         .DATA_W (DATA_W),
         .IDX_W  (CLS_W)
      ) u_argmax (
         .clk     (clk),
         .clear   (first),
         .valid   (accept),
         .data    (s_data_i),
         .idx     (class_cnt),
         .max_idx (best_idx),
         .max_key (best_key)
      );

      assign fin_idx = (first || (in_key > best_key)) ? class_cnt : best_idx;
   end else begin : g_raw
      assign fin_idx = '0;
   end

   // Run control: state, score/image counters and the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         img_cnt   <= '0;
         class_cnt <= '0;
         word_cnt  <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A start clears the old error; a score offered while idle
               // (even alongside start) is still a protocol error.
               err_q <= start_i ? s_valid_i : (err_q | s_valid_i);
               if (start_i) begin
                  state     <= ST_RUN;
                  img_cnt   <= '0;
                  class_cnt <= '0;
                  word_cnt  <= '0;
               end
            end
            ST_RUN: begin
               if (start_i) err_q <= 1'b1;
               if (accept) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (class_last) begin
                     class_cnt <= '0;
                     if (img_last) state <= (MODE == MODE_ARGMAX) ? ST_FLUSH : ST_DONE;
                     else          img_cnt <= img_cnt + 1'b1;
                  end else begin
                     class_cnt <= class_cnt + 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               if (start_i) err_q <= 1'b1;
               state <= ST_DONE;
            end
            ST_DONE: begin
               if (s_valid_i) err_q <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---- p1: registered y_buf write, one cycle after the triggering accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_p1   <= 1'b0;
         last_wr_p1 <= 1'b0;
         addr_p1    <= '0;
         data_p1    <= '0;
      end else begin
         wr_en_p1   <= 1'b0;
         last_wr_p1 <= accept && class_last && img_last;
         if (accept) begin
            if (MODE == MODE_ARGMAX) begin
               if (class_last) begin
                  wr_en_p1 <= 1'b1;
                  addr_p1  <= ADDR_W'(img_cnt) << BYTE_SHIFT;
                  data_p1  <= DATA_W'(fin_idx);
               end
            end else begin
               wr_en_p1 <= 1'b1;
               addr_p1  <= ADDR_W'(word_cnt) << BYTE_SHIFT;
               data_p1  <= s_data_i;
            end
         end
      end
   end

   // ---- p2: completion pulse the cycle after the final write; in argmax
   // mode this lands in DONE, in raw mode in the IDLE cycle that follows.
   // The LED latches with it and is cleared only by an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_p2 <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         done_p2 <= last_wr_p1;
         if ((state == ST_IDLE) && start_i) led_q <= 1'b0;
         else if (last_wr_p1)               led_q <= 1'b1;
      end
   end

   assign y_buf_wr_en = wr_en_p1;
   assign y_buf_en    = wr_en_p1;
   assign y_buf_addr  = addr_p1;
   assign y_buf_data  = data_p1;
   assign err_o       = err_q;
   assign done_intr_o = done_p2;
   assign done_led_o  = led_q;

endmodule

// File: tb/tb_mlp_result_writer.sv
// Bench for mlp_result_writer: raw mode, argmax mode and a small raw
// configuration share one clock; a select picks which one is driven and
// observed. Expected writes come from a real-valued reference model.
module tb_mlp_result_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [31:0] s_data;
   int          sel;

   always #5 clk = ~clk;

   logic        start_v [3];
   logic        valid_v [3];
   logic        rdy     [3];
   logic        en      [3];
   logic        wr      [3];
   logic [31:0] addr    [3];
   logic [31:0] data    [3];
   logic        busy    [3];
   logic        err     [3];
   logic        dintr   [3];
   logic        led     [3];

   assign start_v[0] = start && (sel == 0);
   assign start_v[1] = start && (sel == 1);
   assign start_v[2] = start && (sel == 2);
   assign valid_v[0] = s_valid && (sel == 0);
   assign valid_v[1] = s_valid && (sel == 1);
   assign valid_v[2] = s_valid && (sel == 2);

   mlp_result_writer #(.IMG_NUM(10), .CLASS_NUM(10), .DATA_W(32), .ADDR_W(32),
                       .BYTE_SHIFT(2), .MODE(0)) u_raw (
      .clk(clk), .rst(rst), .start_i(start_v[0]), .s_valid_i(valid_v[0]),
      .s_ready_o(rdy[0]), .s_data_i(s_data), .y_buf_en(en[0]), .y_buf_wr_en(wr[0]),
      .y_buf_addr(addr[0]), .y_buf_data(data[0]), .busy_o(busy[0]), .err_o(err[0]),
      .done_intr_o(dintr[0]), .done_led_o(led[0]));

   mlp_result_writer #(.IMG_NUM(10), .CLASS_NUM(10), .DATA_W(32), .ADDR_W(32),
                       .BYTE_SHIFT(2), .MODE(1)) u_arg (
      .clk(clk), .rst(rst), .start_i(start_v[1]), .s_valid_i(valid_v[1]),
      .s_ready_o(rdy[1]), .s_data_i(s_data), .y_buf_en(en[1]), .y_buf_wr_en(wr[1]),
      .y_buf_addr(addr[1]), .y_buf_data(data[1]), .busy_o(busy[1]), .err_o(err[1]),
      .done_intr_o(dintr[1]), .done_led_o(led[1]));

   mlp_result_writer #(.IMG_NUM(3), .CLASS_NUM(4), .DATA_W(32), .ADDR_W(32),
                       .BYTE_SHIFT(3), .MODE(0)) u_small (
      .clk(clk), .rst(rst), .start_i(start_v[2]), .s_valid_i(valid_v[2]),
      .s_ready_o(rdy[2]), .s_data_i(s_data), .y_buf_en(en[2]), .y_buf_wr_en(wr[2]),
      .y_buf_addr(addr[2]), .y_buf_data(data[2]), .busy_o(busy[2]), .err_o(err[2]),
      .done_intr_o(dintr[2]), .done_led_o(led[2]));

   logic        rdy_m, en_m, wr_m, busy_m, err_m, dintr_m, led_m;
   logic [31:0] addr_m, data_m;
   assign rdy_m   = rdy[sel];
   assign en_m    = en[sel];
   assign wr_m    = wr[sel];
   assign busy_m  = busy[sel];
   assign err_m   = err[sel];
   assign dintr_m = dintr[sel];
   assign led_m   = led[sel];
   assign addr_m  = addr[sel];
   assign data_m  = data[sel];

   int cfg_img  [3] = '{10, 10, 3};
   int cfg_cls  [3] = '{10, 10, 4};
   int cfg_sh   [3] = '{2, 2, 3};
   int cfg_mode [3] = '{0, 1, 0};

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int last_wr_cyc = -10;
   logic [31:0] last_addr = '0;

   logic [31:0] scores   [$];
   logic [31:0] exp_addr [$];
   logic [31:0] exp_data [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Real value of an FP32 bit pattern (normals and subnormals).
   function automatic real fpval(input logic [31:0] b);
      int  e;
      real m, v;
      e = int'(b[30:23]);
      m = real'(b[22:0]) / 8388608.0;
      if (e == 0) v = m * (2.0 ** (-126));
      else        v = (1.0 + m) * (2.0 ** (e - 127));
      return b[31] ? -v : v;
   endfunction

   function automatic logic [31:0] rand_score();
      logic [31:0] v;
      case ($urandom_range(0, 4))
         0:       v = 32'h3F800000;
         1:       v = 32'hBF800000;
         2:       v = 32'h41200000;
         default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 136)), 23'($urandom)};
      endcase
      return v;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Write/done monitor, sampled on the falling edge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("en_eq_wr", en_m, wr_m);
         if (wr_m) begin
            if (exp_addr.size() == 0) begin
               chk("extra_write", 1, 0);
            end else begin
               chk("wr_addr", addr_m, exp_addr.pop_front());
               chk("wr_data", data_m, exp_data.pop_front());
            end
            wr_cnt++;
            last_addr   = addr_m;
            last_wr_cyc = cyc;
         end
         if (dintr_m) begin
            done_cnt++;
            chk("done_after_last_wr", cyc, last_wr_cyc + 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gen_scores(input int kind);
      int n;
      logic [31:0] v;
      n = cfg_img[sel] * cfg_cls[sel];
      scores.delete();
      for (int i = 0; i < n; i++) begin
         if (kind == 0) v = 32'h3F800000 + 32'(i);
         else           v = rand_score();
         scores.push_back(v);
      end
      if (kind == 1) begin
         for (int c = 0; c < 10; c++) begin
            scores[c]      = (c == 7) ? 32'h40000000 : 32'hBF800000;
            scores[10 + c] = (c == 2 || c == 5) ? 32'h41200000 : 32'h00000000;
            scores[20 + c] = (c == 3) ? 32'hBF000000 : 32'hC0000000 + 32'(c);
         end
      end
   endtask

   task automatic build_exp();
      int  ni, nc, sh, bi;
      real best, v;
      ni = cfg_img[sel];
      nc = cfg_cls[sel];
      sh = cfg_sh[sel];
      exp_addr.delete();
      exp_data.delete();
      if (cfg_mode[sel] == 0) begin
         for (int i = 0; i < ni * nc; i++) begin
            exp_addr.push_back(32'(i) << sh);
            exp_data.push_back(scores[i]);
         end
      end else begin
         for (int im = 0; im < ni; im++) begin
            best = fpval(scores[im * nc]);
            bi   = 0;
            for (int c = 1; c < nc; c++) begin
               v = fpval(scores[im * nc + c]);
               if (v > best) begin
                  best = v;
                  bi   = c;
               end
            end
            exp_addr.push_back(32'(im) << sh);
            exp_data.push_back(32'(bi));
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int from, input int to, input bit toggle);
      bit acc;
      int budget;
      for (int k = from; k < to; k++) begin
         if (toggle && k > from) begin
            s_valid = 1'b0;
            tick();
         end
         s_valid = 1'b1;
         s_data  = scores[k];
         acc     = 1'b0;
         budget  = 0;
         while (!acc && budget < 20) begin
            @(negedge clk);
            acc = rdy_m;
            tick();
            budget++;
         end
         if (!acc) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic finish_run(input int w0, input int d0, input int nexp);
      int b;
      b = 0;
      while (done_cnt < d0 + 1 && b < 200) begin
         tick();
         b++;
      end
      chk("done_seen", done_cnt >= d0 + 1, 1);
      repeat (4) tick();
      chk("write_count", wr_cnt - w0, nexp);
      chk("done_count", done_cnt - d0, 1);
      chk("exp_drained", exp_addr.size(), 0);
      chk("led_after_run", led_m, 1);
      chk("busy_after_run", busy_m, 0);
   endtask

   task automatic run_full(input int kind, input bit toggle);
      int w0, d0, nexp;
      gen_scores(kind);
      build_exp();
      nexp = (cfg_mode[sel] == 0) ? cfg_img[sel] * cfg_cls[sel] : cfg_img[sel];
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start();
      chk("start_busy", busy_m, 1);
      chk("start_clr_err", err_m, 0);
      chk("start_clr_led", led_m, 0);
      feed(0, scores.size(), toggle);
      finish_run(w0, d0, nexp);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d exp=done", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      int w0, d0;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; sel = 0;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         chk("rst_ctrl", {rdy_m, wr_m, busy_m, err_m, dintr_m, led_m}, 0);
         chk("rst_addr", addr_m, 0);
         chk("rst_data", data_m, 0);
      end
      sel = 0;
      tick();
      rst = 1'b0;
      tick();

      // Raw mode, 100 back-to-back scores
      run_full(0, 1'b0);
      chk("raw_last_addr", last_addr, 32'h18C);
      chk("raw_err", err_m, 0);

      // Argmax: directed images then random, back-to-back
      sel = 1;
      tick();
      run_full(1, 1'b0);
      // Argmax with valid toggling
      run_full(2, 1'b1);
      chk("arg_last_addr", last_addr, 32'h24);

      // Protocol errors: valid while idle, start while running
      s_valid = 1'b1;
      s_data  = 32'h12345678;
      tick();
      s_valid = 1'b0;
      chk("err_valid_idle", err_m, 1);
      gen_scores(2);
      build_exp();
      w0 = wr_cnt;
      d0 = done_cnt;
      pulse_start();
      chk("err_clr_on_start", err_m, 0);
      chk("led_clr_on_start", led_m, 0);
      feed(0, 5, 1'b0);
      pulse_start();
      chk("err_start_busy", err_m, 1);
      chk("busy_kept", busy_m, 1);
      feed(5, scores.size(), 1'b0);
      finish_run(w0, d0, 10);
      chk("err_sticky", err_m, 1);
      run_full(2, 1'b0);

      // Reset in the middle of a raw run
      sel = 0;
      tick();
      gen_scores(0);
      build_exp();
      pulse_start();
      feed(0, 37, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_ctrl", {rdy_m, wr_m, busy_m, err_m, dintr_m, led_m}, 0);
      chk("midrst_addr", addr_m, 0);
      chk("midrst_data", data_m, 0);
      @(negedge clk);
      chk("midrst_wr_hold", wr_m, 0);
      exp_addr.delete();
      exp_data.delete();
      tick();
      rst = 1'b0;
      tick();
      run_full(2, 1'b0);
      chk("rerun_last_addr", last_addr, 32'h18C);

      // Small configuration
      sel = 2;
      tick();
      run_full(2, 1'b0);
      chk("small_last_addr", last_addr, 32'h58);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
